ascon_perm_ctrl: RTL
====================

# ascon_perm_ctrl

Iterative sequencer for the single-round Ascon permutation datapath `ascon_pc`. It accepts a 320-bit state and applies either p^a (12 rounds) or p^b (8 rounds), one round per clock, using one internal `ascon_pc` instance. It returns the permuted state through a valid/ack handshake. It sits between the AEAD128a mode FSM (initialization, associated data, plaintext and finalization phases) and the round datapath.

## Interface
Parameters: none. The round counts are fixed by the Ascon spec: p^a runs round indices 0..11, and p^b runs round indices 4..11.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  request a permutation; accepted only when ready_o=1
- mode_i  in  1  0 = p^a (12 rounds), 1 = p^b (8 rounds); sampled only when start is accepted
- state_i  in  320  input state; sampled only when start is accepted
- clear_i  in  1  synchronous abort; returns the block to IDLE
- ack_i  in  1  consumer takes the result; meaningful only while valid_o=1
- ready_o  out  1  high in IDLE
- busy_o  out  1  high in RUN
- valid_o  out  1  high in DONE
- state_o  out  320  internal state register, driven directly from the register
- round_o  out  4  current round index fed to `ascon_pc`
- perm_cnt_o  out  16  count of completed permutations; wraps

## Operation
- FSM states: IDLE, RUN, DONE. Decoded outputs: ready_o = (IDLE), busy_o = (RUN), valid_o = (DONE).
- IDLE, start_i=1: load state_reg ← state_i. Set rnd ← 4'd4 if mode_i else 4'd0. Go to RUN.
- RUN, each cycle: state_reg ← ascon_pc(round_i=rnd, S_i=state_reg).S_o.
  - If rnd==11: go to DONE, increment perm_cnt, leave rnd at 11.
  - Else: rnd ← rnd+1.
- DONE: hold state_reg. ack_i=1 → IDLE.
- start_i is ignored outside IDLE, including in DONE while ack_i=1. No back-to-back issue in the same cycle.
- mode_i and state_i changes after acceptance have no effect.
- clear_i=1, any state → IDLE next edge. Priority: reset > clear_i > all other inputs.
  - state_reg and rnd are zeroed; perm_cnt is unchanged.
  - clear_i together with start_i in IDLE: stay in IDLE, start is dropped.
- perm_cnt is 16-bit modulo 2^16: 0xFFFF + 1 = 0x0000. An aborted run does not count.
- round_o = rnd in all states. Values outside 0..11 never occur.
- Reset values: FSM=IDLE, state_reg=0, rnd=0, perm_cnt=0. Therefore ready_o=1, busy_o=0, valid_o=0, state_o=0, round_o=0, perm_cnt_o=0.
- Reset asserted mid-RUN or mid-DONE: all outputs take their reset values immediately. No partial result survives.

## Timing
- Edge E0 (start accepted) → RUN. Rounds are applied on edges E1..En, with n=12 for p^a and n=8 for p^b.
- valid_o rises after En, i.e. n cycles after the accept edge. state_o holds the final state from that point.
- round_o during RUN cycles: 0,1,…,11 for p^a; 4,5,…,11 for p^b.
- Minimum start-to-start period:
  - p^a: 14 cycles (12 RUN + 1 DONE with ack_i high + 1 IDLE).
  - p^b: 10 cycles.
- Backpressure: valid_o and state_o stay stable for any number of cycles with ack_i=0.
- The ack_i edge returns to IDLE; ready_o rises on the following cycle.
- The combinational path is one `ascon_pc` evaluation, register to register. No other logic sits in series with it.

## Test plan
- Reset: after rst_ni deasserts, check ready_o=1, valid_o=0, busy_o=0, state_o=0, round_o=0, perm_cnt_o=0.
- p^a:
  - Stimulus: start with mode_i=0 and state_i = the 64-bit word 0xfeedfacecafebeef repeated 5×.
  - Required: round_o steps 0..11; valid_o rises exactly 12 cycles after accept; state_o equals the bench golden model (12 chained `ascon_pc` evaluations, rounds 0..11); perm_cnt_o=1.
- p^b:
  - Stimulus: same input state with mode_i=1.
  - Required: round_o steps 4..11; valid_o rises after 8 cycles; state_o equals the golden model chaining rounds 4..11.
- Backpressure:
  - Stimulus: hold ack_i=0 for 5 cycles in DONE while pulsing start_i with a new state.
  - Required: state_o and valid_o stay stable; the start is ignored; ack_i=1 → ready_o=1 one cycle later; perm_cnt_o is unchanged by the ignored start.
- Abort and reset:
  - Stimulus: clear_i while round_o=5.
  - Required: IDLE next cycle, state_o=0, valid_o never asserts, perm_cnt_o unchanged.
  - Stimulus: pull rst_ni low mid-RUN, asynchronously between edges.
  - Required: outputs reach reset values before the next edge.
- Counter wrap: run 65536 p^b permutations, each acked immediately. perm_cnt_o must read 0x0000 afterwards and 0x0001 after one more.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation sequencer: p^a (12 rounds) or p^b (8 rounds),
// one round per clock through a single ascon_pc round datapath.

module ascon_pc (
   input  logic [3:0]   round_i,
   input  logic [319:0] s_i,
   output logic [319:0] s_o
);

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] b0, b1, b2, b3, b4;
   logic [63:0] c0, c1, c2, c3, c4;
   logic [63:0] d0, d1, d2, d3, d4;

   assign a0 = s_i[319:256];
   assign a1 = s_i[255:192];
   assign a2 = s_i[191:128] ^ {56'd0, ~round_i, round_i};
   assign a3 = s_i[127:64];
   assign a4 = s_i[63:0];

   // Bitsliced 5-bit S-box
   assign b0 = a0 ^ a4;
   assign b1 = a1;
   assign b2 = a2 ^ a1;
   assign b3 = a3;
   assign b4 = a4 ^ a3;

   assign c0 = b0 ^ (~b1 & b2);
   assign c1 = b1 ^ (~b2 & b3);
   assign c2 = b2 ^ (~b3 & b4);
   assign c3 = b3 ^ (~b4 & b0);
   assign c4 = b4 ^ (~b0 & b1);

   assign d0 = c0 ^ c4;
   assign d1 = c1 ^ c0;
   assign d2 = ~c2;
   assign d3 = c3 ^ c2;
   assign d4 = c4;

   assign s_o = {d0 ^ ror(d0, 19) ^ ror(d0, 28),
                 d1 ^ ror(d1, 61) ^ ror(d1, 39),
                 d2 ^ ror(d2, 1)  ^ ror(d2, 6),
                 d3 ^ ror(d3, 10) ^ ror(d3, 17),
                 d4 ^ ror(d4, 7)  ^ ror(d4, 41)};

endmodule

module ascon_perm_ctrl (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         mode_i,
   input  logic [319:0] state_i,
   input  logic         clear_i,
   input  logic         ack_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         valid_o,
   output logic [319:0] state_o,
   output logic [3:0]   round_o,
   output logic [15:0]  perm_cnt_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

   st_t          st;
   logic [319:0] state_q;
   logic [319:0] pc_out;
   logic [3:0]   rnd;
   logic [15:0]  perm_cnt;

   ascon_pc u_pc (
      .round_i (rnd),
      .s_i     (state_q),
      .s_o     (pc_out)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st       <= IDLE;
         state_q  <= '0;
         rnd      <= '0;
         perm_cnt <= '0;
      end else if (clear_i) begin
         // Abort discards the partial state; the counter only counts completions
         st      <= IDLE;
         state_q <= '0;
         rnd     <= '0;
      end else begin
         unique case (st)
            IDLE: begin
               if (start_i) begin
                  state_q <= state_i;
                  rnd     <= mode_i ? 4'd4 : 4'd0;
                  st      <= RUN;
               end
            end
            RUN: begin
               state_q <= pc_out;
               if (rnd == 4'd11) begin
                  st       <= DONE;
                  perm_cnt <= perm_cnt + 16'd1;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               if (ack_i) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign ready_o    = (st == IDLE);
   assign busy_o     = (st == RUN);
   assign valid_o    = (st == DONE);
   assign state_o    = state_q;
   assign round_o    = rnd;
   assign perm_cnt_o = perm_cnt;

endmodule
